// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul_ctrl sequencer: FSM state encoding,
// index-width helper and packed-matrix element offset helper.
package matmul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ISSUE  = 2'd1;
    localparam state_t WAIT   = 2'd2;
    localparam state_t FINISH = 2'd3;

    // Width of an index counter covering 0..val-1, never narrower than one bit.
    function automatic int clog2_min1(input int val);
        int w;
        w = $clog2(val);
        if (w < 32'sd1) begin
            return 32'sd1;
        end else begin
            return w;
        end
    endfunction

    // Bit offset of element (r,c) in a row-major packed n x n matrix.
    function automatic int elem_lsb(input int r, input int c, input int n, input int width);
        return ((r * n) + c) * width;
    endfunction

endpackage

// File: rtl/mm_operand_mux.sv
// Combinational operand selection for the dot-product engine:
// dp_a carries row row_idx of A, dp_b carries column col_idx of B,
// slot k of each bus holding A[row_idx][k] and B[k][col_idx].
module mm_operand_mux
    import matmul_pkg::*;
#(
    parameter int width = 32,
    parameter int n     = 3,
    parameter int idx_w = 2
) (
    input  logic [width*n*n-1:0] a_mat,
    input  logic [width*n*n-1:0] b_mat,
    input  logic [idx_w-1:0]     row_idx,
    input  logic [idx_w-1:0]     col_idx,
    output logic [width*n-1:0]   dp_a,
    output logic [width*n-1:0]   dp_b
);

    // Gather the selected row of A and column of B slot by slot.
    always_comb begin
        dp_a = '0;
        dp_b = '0;
        for (int k = 0; k < n; k++) begin
            dp_a[k*width +: width] = a_mat[elem_lsb(int'(row_idx), k, n, width) +: width];
            dp_b[k*width +: width] = b_mat[elem_lsb(k, int'(col_idx), n, width) +: width];
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Matrix-product sequencer. Latches A and B on an accepted start, then walks
// the n x n result in row-major order, issuing one dot-product per element to
// an external row_col engine and storing each engine result into C.
// Optional build macro DP_TIMEOUT_EN adds a per-element watchdog that abandons
// the product after TIMEOUT wait cycles and raises a sticky error flag.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int width   = 32,
    parameter int n       = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [width*n*n-1:0] mat_a,
    input  logic [width*n*n-1:0] mat_b,
    output logic [width*n*n-1:0] mat_c,
    output logic                 busy,
    output logic                 done,
    output logic                 dp_start,
    output logic [width*n-1:0]   dp_a,
    output logic [width*n-1:0]   dp_b,
    input  logic [width-1:0]     dp_c,
    input  logic                 dp_done,
    output logic                 error
);

    localparam int IDX_W = clog2_min1(n);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(n - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       i_q, i_d;
    logic [IDX_W-1:0]       j_q, j_d;
    logic [width*n*n-1:0]   a_q, a_d;
    logic [width*n*n-1:0]   b_q, b_d;
    logic [width*n*n-1:0]   c_q, c_d;

`ifdef DP_TIMEOUT_EN
    localparam int WDOG_W = clog2_min1(TIMEOUT + 1);
    // Last count value before the counter would reach TIMEOUT.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic                   error_q, error_d;
`endif

    // State register and all datapath flops, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
`ifdef DP_TIMEOUT_EN
            wdog_q  <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
`ifdef DP_TIMEOUT_EN
            wdog_q  <= wdog_d;
            error_q <= error_d;
`endif
        end
    end

    // Next-state and datapath update: operand latch, index walk, result capture.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
`ifdef DP_TIMEOUT_EN
        wdog_d  = wdog_q;
        error_d = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = mat_a;
                    b_d     = mat_b;
                    i_d     = '0;
                    j_d     = '0;
                    c_d     = '0;
`ifdef DP_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // dp_done is ignored here: the engine clears it on this edge.
                state_d = WAIT;
`ifdef DP_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (dp_done) begin
                    c_d[elem_lsb(int'(i_q), int'(j_q), n, width) +: width] = dp_c;
                    if (j_q < LAST_IDX) begin
                        j_d     = j_q + 1'b1;
                        state_d = ISSUE;
                    end else if (i_q < LAST_IDX) begin
                        j_d     = '0;
                        i_d     = i_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = FINISH;
                    end
                end
`ifdef DP_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    // Element abandoned; C keeps whatever was already stored.
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode of the engine handshake and host status.
    always_comb begin
        dp_start = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            ISSUE: begin
                dp_start = 1'b1;
            end
            WAIT: begin
                dp_start = 1'b0;
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mat_c = c_q;

`ifdef DP_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    mm_operand_mux #(
        .width (width),
        .n     (n),
        .idx_w (IDX_W)
    ) u_operand_mux (
        .a_mat   (a_q),
        .b_mat   (b_q),
        .row_idx (i_q),
        .col_idx (j_q),
        .dp_a    (dp_a),
        .dp_b    (dp_b)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl with a behavioural row_col engine
// (done n+1 cycles after the start sample, cleared on the next start).
`timescale 1ns/1ps
module tb_matmul_ctrl;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int TO  = 20;
    localparam int CW  = W * N * N;
    localparam int PER = N + 3;
    localparam int LAT = N * N * PER;

    typedef logic [CW-1:0] mat_t;
    typedef struct {
        mat_t c;
        int   done_cyc;
        logic err;
        int   n_ds;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    mat_t             mat_a;
    mat_t             mat_b;
    mat_t             mat_c;
    logic             busy;
    logic             done;
    logic             dp_start;
    logic [W*N-1:0]   dp_a;
    logic [W*N-1:0]   dp_b;
    logic [W-1:0]     dp_c;
    logic             dp_done;
    logic             error;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    logic        eng_mute = 1'b0;
    int          eng_cnt;
    logic [W-1:0] eng_res;

    matmul_ctrl #(.width(W), .n(N), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .mat_c    (mat_c),
        .busy     (busy),
        .done     (done),
        .dp_start (dp_start),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_c     (dp_c),
        .dp_done  (dp_done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] dot(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + a[k*W +: W] * b[k*W +: W];
        return s;
    endfunction

    // Behavioural engine: result and done appear n+1 edges after start is sampled.
    always @(posedge clk) begin
        if (rst) begin
            dp_done <= 1'b0;
            dp_c    <= '0;
            eng_cnt <= 0;
            eng_res <= '0;
        end else if (dp_start) begin
            dp_done <= 1'b0;
            eng_cnt <= N + 1;
            eng_res <= dot(dp_a, dp_b);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_mute) begin
                dp_done <= 1'b1;
                dp_c    <= eng_res;
            end
        end
    end

    task automatic chk(input string name, input mat_t act, input mat_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic mat_t pk9(input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [W-1:0] e2,
                                 input logic [W-1:0] e3, input logic [W-1:0] e4, input logic [W-1:0] e5,
                                 input logic [W-1:0] e6, input logic [W-1:0] e7, input logic [W-1:0] e8);
        return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic mat_t fill(input logic [W-1:0] v);
        return {9{v}};
    endfunction

    // Monitor: checks dp_start spacing, busy, and every done against the scoreboard.
    initial begin
        exp_t e;
        int   ds_count  = 0;
        int   last_ds   = -1;
        int   busy_low  = 0;
        logic after_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ds_count   = 0;
                last_ds    = -1;
                busy_low   = 0;
                after_done = 1'b0;
            end else begin
                if (after_done) begin
                    chk("busy_after_done", mat_t'(busy), mat_t'(0));
                    after_done = 1'b0;
                end
                if (exp_q.size() > 0 && !busy) busy_low++;
                if (dp_start) begin
                    if (last_ds >= 0) chk("dp_start_spacing", mat_t'(cyc - last_ds), mat_t'(PER));
                    last_ds = cyc;
                    ds_count++;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mat_c", mat_c, e.c);
                        chk("done_cycle", mat_t'(cyc), mat_t'(e.done_cyc));
                        chk("error_flag", mat_t'(error), mat_t'(e.err));
                        chk("dp_start_count", mat_t'(ds_count), mat_t'(e.n_ds));
                        chk("busy_at_done", mat_t'(busy), mat_t'(1));
                        chk("busy_low_in_run", mat_t'(busy_low), mat_t'(0));
                    end
                    ds_count   = 0;
                    last_ds    = -1;
                    busy_low   = 0;
                    after_done = 1'b1;
                end
            end
        end
    end

    // Issue one product and push its expected outcome; returns with cyc at the start-sample edge.
    task automatic run(input mat_t a, input mat_t b, input mat_t c_exp,
                       input int n_ds, input logic err, input int lat);
        exp_t e;
        @(posedge clk); #1;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.c        = c_exp;
        e.done_cyc = cyc + lat;
        e.err      = err;
        e.n_ds     = n_ds;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got %0d pending products, required 0 within %0d cycles",
                     exp_q.size(), limit);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    mat_t ident;
    mat_t seq9;
    mat_t perm;
    mat_t perm_c;

    initial begin
        ident  = pk9(32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1);
        seq9   = pk9(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9);
        perm   = pk9(32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0);
        perm_c = pk9(32'd1, 32'd3, 32'd2, 32'd4, 32'd6, 32'd5, 32'd7, 32'd9, 32'd8);

        rst   = 1'b1;
        start = 1'b0;
        mat_a = '0;
        mat_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mat_c", mat_c, mat_t'(0));
        chk("reset_busy", mat_t'(busy), mat_t'(0));
        chk("reset_done", mat_t'(done), mat_t'(0));
        chk("reset_dp_start", mat_t'(dp_start), mat_t'(0));
        chk("reset_error", mat_t'(error), mat_t'(0));
        #1 rst = 1'b0;

        // Identity times 1..9.
        run(ident, seq9, seq9, N * N, 1'b0, LAT);
        wait_done(200);

        // All 2 times all 3: every dot product is 18.
        run(fill(32'd2), fill(32'd3), fill(32'd18), N * N, 1'b0, LAT);
        wait_done(200);

        // Engine wraps: 3 * 0x8000_0000 mod 2^32, stored unmodified.
        run(fill(32'h8000_0000), fill(32'd1), fill(32'h8000_0000), N * N, 1'b0, LAT);
        wait_done(200);

        // Start and operand change while busy are ignored.
        run(seq9, perm, perm_c, N * N, 1'b0, LAT);
        repeat (9) @(posedge clk);
        #1;
        mat_a = fill(32'd7);
        mat_b = fill(32'd7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        repeat (60) @(posedge clk);

        // Reset during WAIT of element (1,1), then a fresh product.
        run(ident, seq9, seq9, N * N, 1'b0, LAT);
        repeat (25) @(posedge clk);
        #1;
        chk("partial_c_before_rst", mat_t'(mat_c[4*W-1:0]),
            mat_t'({32'd4, 32'd3, 32'd2, 32'd1}));
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_mat_c", mat_c, mat_t'(0));
        chk("rst_mid_busy", mat_t'(busy), mat_t'(0));
        chk("rst_mid_dp_start", mat_t'(dp_start), mat_t'(0));
        chk("rst_mid_done", mat_t'(done), mat_t'(0));
        #1 rst = 1'b0;
        run(ident, seq9, seq9, N * N, 1'b0, LAT);
        wait_done(200);

`ifdef DP_TIMEOUT_EN
        // Engine never answers: watchdog ends the product with error and empty C.
        eng_mute = 1'b1;
        run(fill(32'd2), fill(32'd3), mat_t'(0), 1, 1'b1, TO + 1);
        wait_done(100);
        eng_mute = 1'b0;
        // Next accepted start clears the error.
        run(fill(32'd2), fill(32'd3), fill(32'd18), N * N, 1'b0, LAT);
        wait_done(200);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
- Initiator/sequencer for the row_col dot-product engine. Latches two n×n matrices from the host, then computes the full n×n product.
- For each output element, in row-major order, it presents row i of A and column j of B to the engine, pulses the engine start, waits for the engine done, and stores the result into C[i][j].
- Host sees one start/done transaction per matrix product.

Parameters:
- width, 32, element width in bits (A, B, C and engine result).
- n, 3, matrix dimension (n ≥ 2).
- TIMEOUT, 255, watchdog limit in cycles per element (used only with DP_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  host request; sampled only in IDLE.
- mat_a  in  width*n*n  matrix A; element (r,c) at bits [(r*n+c)*width +: width].
- mat_b  in  width*n*n  matrix B; same packing.
- mat_c  out  width*n*n  product C; same packing, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, product complete.
- dp_start  out  1  engine start pulse.
- dp_a  out  width*n  row i of A; slot k = A[i][k].
- dp_b  out  width*n  column j of B; slot k = B[k][j].
- dp_c  in  width  engine result.
- dp_done  in  1  engine done; level, cleared by the engine on its next start.
- error  out  1  sticky timeout flag (DP_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: mat_c=0, done=0, dp_start=0, busy=0, error=0, i=j=0, state=IDLE. Latched A and B are cleared to 0.
- Index counters i and j are max(1,$clog2(n)) bits wide.
- State IDLE:
  - start=1 latches mat_a and mat_b into internal registers, sets i=j=0, clears mat_c and error, then goes to ISSUE.
  - start=0 holds in IDLE.
- State ISSUE (1 cycle): dp_start=1. dp_a and dp_b are driven from the latched copies for the current (i,j). Next state is WAIT.
- State WAIT:
  - dp_start=0; dp_a and dp_b are held stable.
  - On dp_done=1: mat_c[(i*n+j)] <= dp_c, then advance the indices.
  - If j<n-1: j++ and go to ISSUE.
  - Else if i<n-1: j=0, i++ and go to ISSUE.
  - Else (i=j=n-1): go to FINISH.
  - dp_done is sampled only in WAIT, never in ISSUE. The engine clears done at the edge that samples dp_start, so a stale done is never captured.
- State FINISH (1 cycle): done=1, busy=1, then IDLE. mat_c holds stable until the next accepted start.
- Outputs are Moore-decoded from state: dp_start, done, busy.
- Latency with row_col (n+1 cycles from start sample to done):
  - n+3 cycles per element.
  - done is high in the cycle that begins n*n*(n+3) edges after the edge sampling start (54 for n=3).
- start while busy is ignored: no restart, no corruption.
- mat_a/mat_b changes after start has been accepted have no effect.
- Element arithmetic belongs to the engine. The controller stores dp_c unmodified, width bits.
- rst mid-operation forces all reset values on the next edge and abandons the current element. The engine must be reset by the same rst.

Optional Feature:
- Macro: DP_TIMEOUT_EN.
- Defined:
  - A per-element counter clears in ISSUE and increments in WAIT.
  - If it reaches TIMEOUT with no dp_done, set error=1, leave C partially filled, and go to FINISH (done pulses).
  - error clears only on rst or the next accepted start.
- Undefined: no counter; WAIT waits indefinitely; error is constant 0.

Decomposition:
- Package matmul_pkg:
  - state encoding localparams: IDLE=0, ISSUE=1, WAIT=2, FINISH=3, 2-bit.
  - index-width function clog2_min1(n).
  - element-offset function elem_lsb(r,c,n,width).
- One sub-module, mm_operand_mux: combinational row/column extraction from the latched A/B by (i,j), producing dp_a and dp_b. Everything else lives in matmul_ctrl.

Test Plan:
- n=3, width=32, A=identity, B=[1..9] -> mat_c=[1..9]; done 54 cycles after start; nine dp_start pulses, each n+3 cycles apart.
- A all 2, B all 3 -> every C element = 18; busy high throughout, low the cycle after the done pulse.
- width=8, A all 16, B all 16 -> every C element = 768 mod 256 = 0 (engine wrap, stored unmodified).
- Second start pulse 10 cycles into a run, with different mat_a -> ignored; result matches the first operands; exactly one done pulse.
- rst asserted during WAIT of element (1,1) -> next cycle: mat_c=0, busy=0, dp_start=0; a fresh start then completes correctly.
- DP_TIMEOUT_EN, TIMEOUT=20, dp_done stuck 0 -> error=1 and done pulse 21 cycles after the first dp_start; mat_c stays all 0.
